// File: rtl/carfield_l2_dual_port_arbiter.sv
// Shares the two L2 SRAM ports between NumReq single-beat requesters: address decode,
// per-port round-robin, registered port requests and in-order response routing.
module carfield_l2_dual_port_arbiter #(
    parameter int unsigned NumReq      = 4,
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned DataWidth   = 64,
    parameter logic [63:0] L2Port0Base = 64'h7800_0000,
    parameter logic [63:0] L2PortSize  = 64'h0020_0000,
    parameter int unsigned MaxTxns     = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumReq-1:0]               req_valid_i,
    output logic [NumReq-1:0]               req_ready_o,
    input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
    input  logic [NumReq-1:0]               req_we_i,
    input  logic [NumReq*DataWidth-1:0]     req_wdata_i,
    input  logic [NumReq*DataWidth/8-1:0]   req_be_i,
    output logic [NumReq-1:0]               rsp_valid_o,
    output logic [NumReq*DataWidth-1:0]     rsp_rdata_o,
    output logic [NumReq-1:0]               rsp_err_o,
    output logic [1:0]                      l2_req_valid_o,
    input  logic [1:0]                      l2_req_ready_i,
    output logic [2*$clog2(L2PortSize)-1:0] l2_req_addr_o,
    output logic [1:0]                      l2_req_we_o,
    output logic [2*DataWidth-1:0]          l2_req_wdata_o,
    output logic [2*DataWidth/8-1:0]        l2_req_be_o,
    input  logic [1:0]                      l2_rsp_valid_i,
    input  logic [2*DataWidth-1:0]          l2_rsp_rdata_i
);

    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned OffWidth = $clog2(L2PortSize);
    localparam int unsigned IdxWidth = $clog2(NumReq);
    localparam int unsigned SumWidth = IdxWidth + 1;
    localparam int unsigned PtrWidth = $clog2(MaxTxns);
    localparam int unsigned CntWidth = PtrWidth + 1;

    localparam logic [AddrWidth-1:0] Base0 = AddrWidth'(L2Port0Base);
    localparam logic [AddrWidth-1:0] Base1 = AddrWidth'(L2Port0Base + L2PortSize);
    localparam logic [AddrWidth-1:0] Limit = AddrWidth'(L2Port0Base + L2PortSize + L2PortSize);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } req_state_e;

    req_state_e r_state   [NumReq];
    req_state_e w_state_d [NumReq];

    logic [NumReq-1:0][AddrWidth-1:0] w_req_addr;
    logic [NumReq-1:0][DataWidth-1:0] w_req_wdata;
    logic [NumReq-1:0][BeWidth-1:0]   w_req_be;
    logic [1:0][DataWidth-1:0]        w_l2_rdata;

    logic [NumReq-1:0] w_sel0, w_sel1, w_err, w_busy, w_err_acc, w_ready;
    logic [1:0][NumReq-1:0]   w_elig;
    logic [1:0]               w_can_gnt, w_gnt_vld, w_pop, w_gnt_we;
    logic [1:0][IdxWidth-1:0] w_gnt_idx;
    logic [1:0][OffWidth-1:0] w_gnt_off;
    logic [1:0][DataWidth-1:0] w_gnt_wdata;
    logic [1:0][BeWidth-1:0]  w_gnt_be;
    logic [SumWidth-1:0]      w_sum;
    logic [1:0][IdxWidth:0]   w_head;

    logic [1:0]               r_l2_valid, r_l2_we;
    logic [1:0][OffWidth-1:0] r_l2_addr;
    logic [1:0][DataWidth-1:0] r_l2_wdata;
    logic [1:0][BeWidth-1:0]  r_l2_be;
    logic [1:0][IdxWidth-1:0] r_rr;
    logic [IdxWidth:0]        r_fifo [2][MaxTxns];
    logic [1:0][PtrWidth-1:0] r_wr_ptr, r_rd_ptr;
    logic [1:0][CntWidth-1:0] r_cnt;

    logic [NumReq-1:0]                r_rsp_valid, r_rsp_err, w_rsp_valid_d, w_rsp_err_d;
    logic [NumReq-1:0][DataWidth-1:0] r_rsp_rdata, w_rsp_rdata_d;

    assign w_req_addr     = req_addr_i;
    assign w_req_wdata    = req_wdata_i;
    assign w_req_be       = req_be_i;
    assign w_l2_rdata     = l2_rsp_rdata_i;
    assign req_ready_o    = w_ready;
    assign rsp_valid_o    = r_rsp_valid;
    assign rsp_err_o      = r_rsp_err;
    assign rsp_rdata_o    = r_rsp_rdata;
    assign l2_req_valid_o = r_l2_valid;
    assign l2_req_addr_o  = r_l2_addr;
    assign l2_req_we_o    = r_l2_we;
    assign l2_req_wdata_o = r_l2_wdata;
    assign l2_req_be_o    = r_l2_be;

    // Address decode and busy (transaction outstanding) flags
    always_comb begin
        w_sel0 = '0;
        w_sel1 = '0;
        w_err  = '0;
        w_busy = '0;
        for (int i = 0; i < NumReq; i++) begin
            w_sel0[i] = (w_req_addr[i] >= Base0) && (w_req_addr[i] < Base1);
            w_sel1[i] = (w_req_addr[i] >= Base1) && (w_req_addr[i] < Limit);
            w_err[i]  = ~(w_sel0[i] | w_sel1[i]);
            w_busy[i] = (r_state[i] == ST_WAIT);
        end
    end

    // Per-port round-robin: first eligible requester at or after the pointer
    always_comb begin
        w_elig    = '0;
        w_can_gnt = '0;
        w_gnt_vld = '0;
        w_gnt_idx = '0;
        w_sum     = '0;
        for (int i = 0; i < NumReq; i++) begin
            w_elig[0][i] = rst_ni & req_valid_i[i] & ~w_busy[i] & w_sel0[i];
            w_elig[1][i] = rst_ni & req_valid_i[i] & ~w_busy[i] & w_sel1[i];
        end
        for (int p = 0; p < 2; p++) begin
            w_can_gnt[p] = (~r_l2_valid[p] | l2_req_ready_i[p]) &&
                           (r_cnt[p] < CntWidth'(MaxTxns));
            for (int k = 0; k < NumReq; k++) begin
                w_sum = {1'b0, r_rr[p]} + SumWidth'(k);
                if (w_sum >= SumWidth'(NumReq)) begin
                    w_sum = w_sum - SumWidth'(NumReq);
                end
                if (!w_gnt_vld[p] && w_can_gnt[p] && w_elig[p][w_sum[IdxWidth-1:0]]) begin
                    w_gnt_vld[p] = 1'b1;
                    w_gnt_idx[p] = w_sum[IdxWidth-1:0];
                end
            end
        end
    end

    // Handshakes, error accepts and the granted request payload
    always_comb begin
        w_ready     = '0;
        w_err_acc   = '0;
        w_gnt_off   = '0;
        w_gnt_we    = '0;
        w_gnt_wdata = '0;
        w_gnt_be    = '0;
        for (int i = 0; i < NumReq; i++) begin
            w_err_acc[i] = rst_ni & req_valid_i[i] & ~w_busy[i] & w_err[i];
            w_ready[i]   = w_err_acc[i] |
                           (w_gnt_vld[0] && (w_gnt_idx[0] == IdxWidth'(i))) |
                           (w_gnt_vld[1] && (w_gnt_idx[1] == IdxWidth'(i)));
        end
        w_gnt_off[0]   = OffWidth'(w_req_addr[w_gnt_idx[0]] - Base0);
        w_gnt_off[1]   = OffWidth'(w_req_addr[w_gnt_idx[1]] - Base1);
        for (int p = 0; p < 2; p++) begin
            w_gnt_we[p]    = req_we_i[w_gnt_idx[p]];
            w_gnt_wdata[p] = w_req_wdata[w_gnt_idx[p]];
            w_gnt_be[p]    = w_req_be[w_gnt_idx[p]];
        end
    end

    // Response routing: FIFO heads {we, idx} pick the target; writes and errors return 0
    always_comb begin
        w_rsp_valid_d = w_err_acc;
        w_rsp_err_d   = w_err_acc;
        w_rsp_rdata_d = '0;
        w_pop         = '0;
        w_head        = '0;
        for (int p = 0; p < 2; p++) begin
            w_head[p] = r_fifo[p][r_rd_ptr[p]];
            w_pop[p]  = l2_rsp_valid_i[p] && (r_cnt[p] != '0);
            if (w_pop[p]) begin
                w_rsp_valid_d[w_head[p][IdxWidth-1:0]] = 1'b1;
                if (!w_head[p][IdxWidth]) begin
                    w_rsp_rdata_d[w_head[p][IdxWidth-1:0]] = w_l2_rdata[p];
                end
            end
        end
    end

    // Port output registers, round-robin pointers and outstanding FIFOs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_l2_valid  <= '0;
            r_l2_we     <= '0;
            r_l2_addr   <= '0;
            r_l2_wdata  <= '0;
            r_l2_be     <= '0;
            r_rr        <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= '0;
            r_rsp_rdata <= '0;
            for (int p = 0; p < 2; p++) begin
                for (int t = 0; t < MaxTxns; t++) begin
                    r_fifo[p][t] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_gnt_vld[p]) begin
                    r_l2_valid[p] <= 1'b1;
                    r_l2_addr[p]  <= w_gnt_off[p];
                    r_l2_we[p]    <= w_gnt_we[p];
                    r_l2_wdata[p] <= w_gnt_wdata[p];
                    r_l2_be[p]    <= w_gnt_be[p];
                    r_rr[p]       <= (w_gnt_idx[p] == IdxWidth'(NumReq - 1)) ? '0
                                     : w_gnt_idx[p] + IdxWidth'(1);
                    r_fifo[p][r_wr_ptr[p]] <= {w_gnt_we[p], w_gnt_idx[p]};
                    r_wr_ptr[p]   <= r_wr_ptr[p] + PtrWidth'(1);
                end else if (l2_req_ready_i[p]) begin
                    r_l2_valid[p] <= 1'b0;
                end
                if (w_pop[p]) begin
                    r_rd_ptr[p] <= r_rd_ptr[p] + PtrWidth'(1);
                end
                if (w_gnt_vld[p] && !w_pop[p]) begin
                    r_cnt[p] <= r_cnt[p] + CntWidth'(1);
                end else if (!w_gnt_vld[p] && w_pop[p]) begin
                    r_cnt[p] <= r_cnt[p] - CntWidth'(1);
                end
            end
            r_rsp_valid <= w_rsp_valid_d;
            r_rsp_err   <= w_rsp_err_d;
            r_rsp_rdata <= w_rsp_rdata_d;
        end
    end

    // Requester state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumReq; i++) begin
                r_state[i] <= ST_IDLE;
            end
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                r_state[i] <= w_state_d[i];
            end
        end
    end

    // Requester next state: WAIT holds off new requests until the response pulse
    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            w_state_d[i] = r_state[i];
            case (r_state[i])
                ST_IDLE: begin
                    if (req_valid_i[i]) begin
                        w_state_d[i] = w_ready[i] ? ST_WAIT : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!req_valid_i[i]) begin
                        w_state_d[i] = ST_IDLE;
                    end else if (w_ready[i]) begin
                        w_state_d[i] = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_rsp_valid[i]) begin
                        w_state_d[i] = ST_IDLE;
                    end
                end
                default: w_state_d[i] = ST_IDLE;
            endcase
        end
    end

    for (genvar gp = 0; gp < 2; gp++) begin : g_rsp_chk
        a_rsp_needs_txn : assert property (@(posedge clk_i) disable iff (!rst_ni)
            l2_rsp_valid_i[gp] |-> (r_cnt[gp] != '0));
    end

endmodule

// File: tb/tb_carfield_l2_dual_port_arbiter.sv
// Directed bench for carfield_l2_dual_port_arbiter with a fixed-latency L2 port model.
module tb_carfield_l2_dual_port_arbiter;

    localparam int NR = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int OW = 21;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic [NR-1:0]          req_valid_i, req_ready_o, req_we_i;
    logic [NR-1:0][AW-1:0]  req_addr_i;
    logic [NR-1:0][DW-1:0]  req_wdata_i;
    logic [NR-1:0][7:0]     req_be_i;
    logic [NR-1:0]          rsp_valid_o, rsp_err_o;
    logic [NR-1:0][DW-1:0]  rsp_rdata_o;
    logic [1:0]             l2_req_valid_o, l2_req_ready_i, l2_req_we_o, l2_rsp_valid_i;
    logic [1:0][OW-1:0]     l2_req_addr_o;
    logic [1:0][DW-1:0]     l2_req_wdata_o, l2_rsp_rdata_i;
    logic [1:0][7:0]        l2_req_be_o;

    always #5 clk_i = ~clk_i;

    carfield_l2_dual_port_arbiter dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (req_addr_i),
        .req_we_i       (req_we_i),
        .req_wdata_i    (req_wdata_i),
        .req_be_i       (req_be_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .l2_req_valid_o (l2_req_valid_o),
        .l2_req_ready_i (l2_req_ready_i),
        .l2_req_addr_o  (l2_req_addr_o),
        .l2_req_we_o    (l2_req_we_o),
        .l2_req_wdata_o (l2_req_wdata_o),
        .l2_req_be_o    (l2_req_be_o),
        .l2_rsp_valid_i (l2_rsp_valid_i),
        .l2_rsp_rdata_i (l2_rsp_rdata_i)
    );

    typedef struct {
        int          due;
        logic [63:0] data;
    } prsp_t;

    prsp_t       pq0[$], pq1[$];
    int          lat [2];
    logic [63:0] pat [2];

    int          checks = 0, failures = 0;
    int          cyc = 0;
    int          hs_cyc  [NR];
    int          rsp_cyc [NR];
    logic [63:0] rsp_data[NR];
    logic        rsp_errl[NR];
    int          hs_order[$], rsp_order[$];
    logic [63:0] acc_addr0[$], acc_addr1[$];
    int          hs_total, rsp_total, l2v_cycles, stab_viol;
    logic        prev_stall0 = 1'b0;
    logic [OW-1:0] prev_addr0 = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [63:0] addr, input logic we);
        req_addr_i[i]  = addr;
        req_we_i[i]    = we;
        req_wdata_i[i] = {32'hA5A5_0000, 32'(i)};
        req_be_i[i]    = 8'hFF;
        req_valid_i[i] = 1'b1;
    endtask

    task automatic clear_logs();
        hs_order.delete();
        rsp_order.delete();
        acc_addr0.delete();
        acc_addr1.delete();
        hs_total   = 0;
        rsp_total  = 0;
        l2v_cycles = 0;
        stab_viol  = 0;
    endtask

    // One clock: observe at the falling edge, then update requesters and port model after the rising edge
    task automatic step();
        logic [NR-1:0] hs_mask;
        prsp_t         e;
        hs_mask = '0;
        @(negedge clk_i);
        for (int i = 0; i < NR; i++) begin
            if (req_valid_i[i] && req_ready_o[i]) begin
                hs_mask[i] = 1'b1;
                hs_cyc[i]  = cyc;
                hs_order.push_back(i);
                hs_total++;
            end
            if (rsp_valid_o[i]) begin
                rsp_cyc[i]  = cyc;
                rsp_data[i] = rsp_rdata_o[i];
                rsp_errl[i] = rsp_err_o[i];
                rsp_order.push_back(i);
                rsp_total++;
            end
        end
        if (l2_req_valid_o != 2'b00) l2v_cycles++;
        if (prev_stall0 && (!l2_req_valid_o[0] || l2_req_addr_o[0] != prev_addr0)) stab_viol++;
        prev_stall0 = l2_req_valid_o[0] & ~l2_req_ready_i[0];
        prev_addr0  = l2_req_addr_o[0];
        if (l2_req_valid_o[0] && l2_req_ready_i[0]) begin
            e.due = cyc + lat[0]; e.data = pat[0];
            pq0.push_back(e);
            acc_addr0.push_back(64'(l2_req_addr_o[0]));
        end
        if (l2_req_valid_o[1] && l2_req_ready_i[1]) begin
            e.due = cyc + lat[1]; e.data = pat[1];
            pq1.push_back(e);
            acc_addr1.push_back(64'(l2_req_addr_o[1]));
        end
        @(posedge clk_i);
        #1;
        cyc++;
        req_valid_i    = req_valid_i & ~hs_mask;
        l2_rsp_valid_i = 2'b00;
        l2_rsp_rdata_i = '0;
        if (pq0.size() > 0 && pq0[0].due == cyc) begin
            l2_rsp_valid_i[0] = 1'b1;
            l2_rsp_rdata_i[0] = pq0[0].data;
            void'(pq0.pop_front());
        end
        if (pq1.size() > 0 && pq1[0].due == cyc) begin
            l2_rsp_valid_i[1] = 1'b1;
            l2_rsp_rdata_i[1] = pq1[0].data;
            void'(pq1.pop_front());
        end
    endtask

    task automatic run_rsp(input int target, input int budget, input string tag);
        for (int c = 0; c < budget && rsp_total < target; c++) step();
        check_eq({tag, "_rsp_count"}, 64'(rsp_total), 64'(target));
    endtask

    initial begin
        rst_ni = 1'b0;
        req_valid_i = '0; req_we_i = '0; req_addr_i = '0; req_wdata_i = '0; req_be_i = '0;
        l2_req_ready_i = 2'b11; l2_rsp_valid_i = '0; l2_rsp_rdata_i = '0;
        lat[0] = 2; lat[1] = 2; pat[0] = '0; pat[1] = '0;
        clear_logs();
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_req_ready", 64'(req_ready_o), 64'h0);
        check_eq("rst_l2_valid", 64'(l2_req_valid_o), 64'h0);
        check_eq("rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
        check_eq("rst_rsp_rdata", 64'(rsp_rdata_o[0] | rsp_rdata_o[3]), 64'h0);
        rst_ni = 1'b1;
        step(); step();

        // Two write bursts to port 0: grants 0,1,2,3 on consecutive cycles, pointer wraps
        for (int b = 0; b < 2; b++) begin
            clear_logs();
            lat[0] = 1; pat[0] = 64'h5555_5555_5555_5555;
            for (int i = 0; i < NR; i++) set_req(i, 64'h7800_0100 + 64'(i * 8), 1'b1);
            run_rsp(4, 40, "burst");
            check_eq("burst_hs_count", 64'(hs_total), 64'd4);
            for (int k = 0; k < hs_order.size(); k++) begin
                check_eq("burst_grant_order", 64'(hs_order[k]), 64'(k));
                check_eq("burst_grant_cycle", 64'(hs_cyc[k] - hs_cyc[0]), 64'(k));
            end
            check_eq("burst_write_rdata", rsp_data[2], 64'h0);
            check_eq("burst_write_err", 64'(rsp_errl[2]), 64'h0);
            if (acc_addr0.size() > 3) check_eq("burst_offset3", acc_addr0[3], 64'h118);
        end

        // Single read with 2-cycle port latency
        clear_logs();
        lat[0] = 2; pat[0] = 64'hDEAD_BEEF;
        set_req(0, 64'h7800_0010, 1'b0);
        run_rsp(1, 20, "read");
        check_eq("read_offset", (acc_addr0.size() > 0) ? acc_addr0[0] : 64'hBAD, 64'h10);
        check_eq("read_rdata", rsp_data[0], 64'hDEAD_BEEF);
        check_eq("read_err", 64'(rsp_errl[0]), 64'h0);
        check_eq("read_latency", 64'(rsp_cyc[0] - hs_cyc[0]), 64'd4);

        // Both ports granted in the same cycle
        clear_logs();
        pat[0] = 64'h1111; pat[1] = 64'h2222;
        set_req(1, 64'h7820_0040, 1'b0);
        set_req(2, 64'h7800_0000, 1'b0);
        run_rsp(2, 20, "par");
        check_eq("par_same_cycle", 64'(hs_cyc[1]), 64'(hs_cyc[2]));
        check_eq("par_p1_offset", (acc_addr1.size() > 0) ? acc_addr1[0] : 64'hBAD, 64'h40);
        check_eq("par_p0_offset", (acc_addr0.size() > 0) ? acc_addr0[0] : 64'hBAD, 64'h0);
        check_eq("par_r1_rdata", rsp_data[1], 64'h2222);
        check_eq("par_r2_rdata", rsp_data[2], 64'h1111);

        // Last doubleword of port 1
        clear_logs();
        pat[1] = 64'h7777;
        set_req(0, 64'h783F_FFF8, 1'b0);
        run_rsp(1, 20, "top");
        check_eq("top_p1_offset", (acc_addr1.size() > 0) ? acc_addr1[0] : 64'hBAD, 64'h1F_FFF8);
        check_eq("top_err", 64'(rsp_errl[0]), 64'h0);

        // Decode errors: just above port 1 and just below port 0
        for (int e = 0; e < 2; e++) begin
            clear_logs();
            set_req(3, (e == 0) ? 64'h7840_0000 : 64'h77FF_FFF8, 1'b0);
            run_rsp(1, 10, "err");
            check_eq("err_latency", 64'(rsp_cyc[3] - hs_cyc[3]), 64'd1);
            check_eq("err_flag", 64'(rsp_errl[3]), 64'h1);
            check_eq("err_rdata", rsp_data[3], 64'h0);
            check_eq("err_no_port", 64'(l2v_cycles), 64'h0);
        end

        // Port 0 stalled: one grant (pointer is at 3), request held stable, then in-order drain
        clear_logs();
        l2_req_ready_i[0] = 1'b0; pat[0] = 64'h3333;
        for (int i = 0; i < NR; i++) set_req(i, 64'h7800_0200 + 64'(i * 16), 1'b0);
        repeat (10) step();
        check_eq("stall_hs_count", 64'(hs_total), 64'd1);
        check_eq("stall_first", (hs_order.size() > 0) ? 64'(hs_order[0]) : 64'hBAD, 64'd3);
        check_eq("stall_ready", 64'(req_ready_o), 64'h0);
        check_eq("stall_l2_valid", 64'(l2_req_valid_o[0]), 64'h1);
        check_eq("stall_l2_addr", 64'(l2_req_addr_o[0]), 64'h230);
        l2_req_ready_i[0] = 1'b1;
        run_rsp(4, 40, "drain");
        for (int k = 0; k < rsp_order.size(); k++) begin
            check_eq("drain_order", 64'(rsp_order[k]), 64'((k + 3) % 4));
        end
        check_eq("drain_rdata", rsp_data[1], 64'h3333);
        check_eq("stall_stable", 64'(stab_viol), 64'h0);

        // Asynchronous reset with three port-0 transactions in flight
        clear_logs();
        lat[0] = 10; pat[0] = 64'h4444;
        for (int i = 0; i < 3; i++) set_req(i, 64'h7800_0300 + 64'(i * 8), 1'b0);
        for (int c = 0; c < 20 && hs_total < 3; c++) step();
        check_eq("inflight_hs", 64'(hs_total), 64'd3);
        rst_ni = 1'b0;
        #1;
        check_eq("mid_rst_l2_valid", 64'(l2_req_valid_o), 64'h0);
        check_eq("mid_rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
        check_eq("mid_rst_ready", 64'(req_ready_o), 64'h0);
        req_valid_i = '0; l2_rsp_valid_i = '0;
        pq0.delete(); pq1.delete();
        step(); step();
        rst_ni = 1'b1;
        clear_logs();
        repeat (15) step();
        check_eq("post_rst_no_stale", 64'(rsp_total), 64'h0);
        lat[0] = 2; pat[0] = 64'hCAFE_F00D_1234_5678;
        set_req(0, 64'h7800_0020, 1'b0);
        run_rsp(1, 20, "post_rst");
        check_eq("post_rst_rdata", rsp_data[0], 64'hCAFE_F00D_1234_5678);
        check_eq("post_rst_err", 64'(rsp_errl[0]), 64'h0);
        check_eq("post_rst_offset", (acc_addr0.size() > 0) ? acc_addr0[0] : 64'hBAD, 64'h20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
